// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the WB stage and a buffered multi-cycle
// result source, and keeps per-register counts of outstanding multi-cycle writes for decode.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] mc_waddr,
  input  logic [DATA_W-1:0] mc_wdata,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_waddr,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              busy1,
  output logic              busy2,
  output logic              stall_req,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int NREG  = 1 << ADDR_W;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_r;
  logic [PTR_W:0]    rd_ptr_r;
  logic [1:0]        sb_r [NREG];
  logic [SC_W-1:0]   starve_r;
  logic              stall_r;

  logic              empty_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              inc_s;
  logic              dec_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;
  logic [NREG-1:0]   inc_vec_s;
  logic [NREG-1:0]   dec_vec_s;
  logic              rf_we_s;
  logic [ADDR_W-1:0] rf_waddr_s;
  logic [DATA_W-1:0] rf_wdata_s;

  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign full_s      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign head_addr_s = fifo_addr_r[rd_ptr_r[PTR_W-1:0]];
  assign head_data_s = fifo_data_r[rd_ptr_r[PTR_W-1:0]];

  // Ready is taken from registered occupancy only; a same-cycle pop never opens it.
  assign mc_ready = !full_s;
  assign push_s   = mc_valid && !full_s;

  // Write-port arbitration: WB always wins, otherwise drain the FIFO head.
  always_comb begin
    rf_we_s    = 1'b0;
    rf_waddr_s = '0;
    rf_wdata_s = '0;
    pop_s      = 1'b0;
    if (wb_we) begin
      rf_we_s    = (wb_waddr != '0);
      rf_waddr_s = wb_waddr;
      rf_wdata_s = wb_wdata;
    end else if (!empty_s) begin
      pop_s      = 1'b1;
      rf_we_s    = (head_addr_s != '0);
      rf_waddr_s = head_addr_s;
      rf_wdata_s = head_data_s;
    end else begin
      rf_we_s    = 1'b0;
    end
  end

  // The register file must see no write while reset is held, whatever WB presents.
  assign rf_we    = rf_we_s && clr_n;
  assign rf_waddr = rf_waddr_s;
  assign rf_wdata = rf_wdata_s;

  // Multi-cycle result FIFO storage and pointers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_r[i] <= '0;
        fifo_data_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r[PTR_W-1:0]] <= mc_waddr;
        fifo_data_r[wr_ptr_r[PTR_W-1:0]] <= mc_wdata;
        wr_ptr_r                         <= wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  assign iss_ready = (iss_waddr == '0) ? 1'b1 : (sb_r[iss_waddr] != 2'd3);
  assign inc_s     = iss_valid && iss_ready && (iss_waddr != '0);
  assign dec_s     = pop_s && (head_addr_s != '0);
  assign inc_vec_s = inc_s ? (NREG'(1) << iss_waddr) : '0;
  assign dec_vec_s = dec_s ? (NREG'(1) << head_addr_s) : '0;

  // Pending-write scoreboard; an issue and a retire on one register cancel out.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NREG; i++) begin
        sb_r[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i == 0) begin
          sb_r[i] <= 2'd0;
        end else if (inc_vec_s[i] && !dec_vec_s[i] && (sb_r[i] != 2'd3)) begin
          sb_r[i] <= sb_r[i] + 2'd1;
        end else if (dec_vec_s[i] && !inc_vec_s[i] && (sb_r[i] != 2'd0)) begin
          sb_r[i] <= sb_r[i] - 2'd1;
        end else begin
          sb_r[i] <= sb_r[i];
        end
      end
    end
  end

  assign busy1 = (raddr1 != '0) && (sb_r[raddr1] != 2'd0);
  assign busy2 = (raddr2 != '0) && (sb_r[raddr2] != 2'd0);

  // Starvation counter: cycles the FIFO head has been held off by WB.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      starve_r <= '0;
    end else if (empty_s || pop_s) begin
      starve_r <= '0;
    end else if (wb_we && (starve_r != STARVE_MAX)) begin
      starve_r <= starve_r + 1'b1;
    end else begin
      starve_r <= starve_r;
    end
  end

  // Stall request trails the saturated counter by one cycle and drops once the head pops.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stall_r <= 1'b0;
    end else begin
      stall_r <= (starve_r == STARVE_MAX) && !empty_s && !pop_s;
    end
  end

  assign stall_req = stall_r;

endmodule
